// File: rtl/pixel_framebuffer_writer.sv
// Pixel framebuffer writer: absorbs the rasterizer's non-stallable pixel
// stream in a small FIFO and drains it to the SRAM controller over req/ack.
module pixel_framebuffer_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_sig_write_pixel,
  input  logic [15:0]       in_pixel_x,
  input  logic [15:0]       in_pixel_y,
  input  logic [1:0]        in_pixel_depth,
  input  logic [15:0]       in_pixel_color,
  output logic              out_mem_write_req,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [15:0]       out_mem_data,
  output logic [1:0]        out_mem_depth,
  input  logic              in_mem_write_ack,
  output logic              out_sig_fifo_full,
  output logic              out_sig_writer_idle,
  output logic [15:0]       out_drop_count
);

  localparam int          PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] X_LIM  = 16'(FB_WIDTH);
  localparam logic [15:0] Y_LIM  = 16'(FB_HEIGHT);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  // One buffered write: everything the SRAM controller needs.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       color;
    logic [1:0]        depth;
  } pix_t;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state, state_nxt;
  pix_t             mem [FIFO_DEPTH];
  pix_t             in_pix;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             fifo_empty, fifo_full_now;
  logic             in_range;
  logic             push, pop, drop;
  logic             req_nxt;

  assign fifo_empty    = (count == '0);
  assign fifo_full_now = (count == CNT_FULL);

  // Off-screen pixels are clipped before they can touch the FIFO or the drop count.
  assign in_range = (in_pixel_x < X_LIM) && (in_pixel_y < Y_LIM);

  // Linear address; operands are narrowed to ADDR_W first, which keeps the
  // low ADDR_W bits of y*FB_WIDTH + x exact.
  assign in_pix.addr  = ADDR_W'(in_pixel_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(in_pixel_x);
  assign in_pix.color = in_pixel_color;
  assign in_pix.depth = in_pixel_depth;

  // A full FIFO still accepts a pixel when the head leaves on the same edge.
  assign push = in_sig_write_pixel && in_range && (!fifo_full_now || pop);
  assign drop = in_sig_write_pixel && in_range && fifo_full_now && !pop;

  // Write FSM: state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Write FSM: next state. IDLE launches on any buffered pixel; WRITE only
  // moves on an ack, chaining straight into the next entry if one is waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = WRITE;
      WRITE: if (in_mem_write_ack && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write FSM: outputs. Pop whenever the output registers are free to take
  // the head: in IDLE, or in WRITE on the edge the current write is acked.
  always_comb begin
    pop     = 1'b0;
    req_nxt = 1'b0;
    case (state)
      IDLE:  pop = !fifo_empty;
      WRITE: pop = in_mem_write_ack && !fifo_empty;
      default: pop = 1'b0;
    endcase
    req_nxt = (state_nxt == WRITE);
  end

  // Occupancy after this edge.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_pix;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // Memory-side output registers; the head is loaded on every pop and held
  // stable until the controller acks it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_mem_write_req <= 1'b0;
      out_mem_addr      <= '0;
      out_mem_data      <= '0;
      out_mem_depth     <= '0;
    end else begin
      out_mem_write_req <= req_nxt;
      if (pop) begin
        out_mem_addr  <= mem[rd_ptr].addr;
        out_mem_data  <= mem[rd_ptr].color;
        out_mem_depth <= mem[rd_ptr].depth;
      end
    end
  end

  // Registered status flags reflecting the state after this edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_sig_fifo_full   <= 1'b0;
      out_sig_writer_idle <= 1'b1;
    end else begin
      out_sig_fifo_full   <= (count_nxt == CNT_FULL);
      out_sig_writer_idle <= (count_nxt == '0) && (state_nxt == IDLE);
    end
  end

  // Saturating count of in-range pixels lost to overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           out_drop_count <= '0;
    else if (drop && out_drop_count != '1) out_drop_count <= out_drop_count + 16'd1;
  end

endmodule

// File: tb/tb_pixel_framebuffer_writer.sv
// Directed bench for pixel_framebuffer_writer: a vector table for the
// single-pixel and clipping cases, hand sequences for burst, overflow,
// full push+pop and mid-write reset.
module tb_pixel_framebuffer_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wp;
  logic [15:0] px, py, pc;
  logic [1:0]  pd;
  logic        req, ack, full, idle;
  logic [17:0] addr;
  logic [15:0] data, drop_cnt;
  logic [1:0]  dep;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pixel_framebuffer_writer #(
    .FB_WIDTH(320), .FB_HEIGHT(240), .ADDR_W(18), .FIFO_DEPTH(8)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .in_sig_write_pixel (wp),
    .in_pixel_x         (px),
    .in_pixel_y         (py),
    .in_pixel_depth     (pd),
    .in_pixel_color     (pc),
    .out_mem_write_req  (req),
    .out_mem_addr       (addr),
    .out_mem_data       (data),
    .out_mem_depth      (dep),
    .in_mem_write_ack   (ack),
    .out_sig_fifo_full  (full),
    .out_sig_writer_idle(idle),
    .out_drop_count     (drop_cnt)
  );

  typedef struct packed {
    logic        wp;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  d;
    logic [15:0] c;
    logic        ack;
    logic        req;
    logic        cm;     // compare addr/data/depth on this vector
    logic [17:0] addr;
    logic [15:0] data;
    logic [1:0]  dep;
    logic        full;
    logic        idle;
    logic [15:0] drop;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input logic w, input logic [15:0] x, input logic [15:0] y,
                         input logic [1:0] d, input logic [15:0] c);
    wp = w; px = x; py = y; pd = d; pc = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wp  x    y    d  c        ack req cm addr   data     dep full idle drop
    vec[0] = '{1'b1, 16'd5,   16'd2,   2'd1, 16'hF800, 1'b0, 1'b0, 1'b1, 18'd0,     16'h0000, 2'd0, 1'b0, 1'b0, 16'd0};
    vec[1] = '{1'b0, 16'd0,   16'd0,   2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 18'd645,   16'hF800, 2'd1, 1'b0, 1'b0, 16'd0};
    vec[2] = '{1'b0, 16'd0,   16'd0,   2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 18'd645,   16'hF800, 2'd1, 1'b0, 1'b0, 16'd0};
    vec[3] = '{1'b0, 16'd0,   16'd0,   2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 18'd0,     16'h0000, 2'd0, 1'b0, 1'b1, 16'd0};
    vec[4] = '{1'b0, 16'd0,   16'd0,   2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 18'd0,     16'h0000, 2'd0, 1'b0, 1'b1, 16'd0};
    vec[5] = '{1'b1, 16'd320, 16'd0,   2'd0, 16'h1111, 1'b0, 1'b0, 1'b0, 18'd0,     16'h0000, 2'd0, 1'b0, 1'b1, 16'd0};
    vec[6] = '{1'b1, 16'd0,   16'd240, 2'd0, 16'h2222, 1'b0, 1'b0, 1'b0, 18'd0,     16'h0000, 2'd0, 1'b0, 1'b1, 16'd0};
    vec[7] = '{1'b1, 16'd319, 16'd239, 2'd3, 16'h1234, 1'b0, 1'b0, 1'b0, 18'd0,     16'h0000, 2'd0, 1'b0, 1'b0, 16'd0};
    vec[8] = '{1'b0, 16'd0,   16'd0,   2'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 18'd76799, 16'h1234, 2'd3, 1'b0, 1'b0, 16'd0};
    vec[9] = '{1'b0, 16'd0,   16'd0,   2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 18'd0,     16'h0000, 2'd0, 1'b0, 1'b1, 16'd0};

    // Reset state
    reset_n = 1'b0; ack = 1'b0;
    set_pix(1'b0, 16'd0, 16'd0, 2'd0, 16'd0);
    #12;
    chk("rst_req",  32'(req),      32'd0);
    chk("rst_addr", 32'(addr),     32'd0);
    chk("rst_data", 32'(data),     32'd0);
    chk("rst_full", 32'(full),     32'd0);
    chk("rst_idle", 32'(idle),     32'd1);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    #1 reset_n = 1'b1;

    // Single pixel and clipping vectors
    for (int i = 0; i < NV; i++) begin
      set_pix(vec[i].wp, vec[i].x, vec[i].y, vec[i].d, vec[i].c);
      ack = vec[i].ack;
      tick();
      chk($sformatf("v%0d_req", i),  32'(req),      32'(vec[i].req));
      chk($sformatf("v%0d_full", i), 32'(full),     32'(vec[i].full));
      chk($sformatf("v%0d_idle", i), 32'(idle),     32'(vec[i].idle));
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vec[i].drop));
      if (vec[i].cm) begin
        chk($sformatf("v%0d_addr", i), 32'(addr), 32'(vec[i].addr));
        chk($sformatf("v%0d_data", i), 32'(data), 32'(vec[i].data));
        chk($sformatf("v%0d_dep", i),  32'(dep),  32'(vec[i].dep));
      end
    end

    // Six-pixel burst with ack held high: one write per cycle in order
    ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) set_pix(1'b1, 16'(10 + i), 16'd3, 2'(i), 16'hA000 + 16'(i));
      else       set_pix(1'b0, 16'd0, 16'd0, 2'd0, 16'd0);
      tick();
      chk($sformatf("burst%0d_full", i), 32'(full), 32'd0);
      chk($sformatf("burst%0d_drop", i), 32'(drop_cnt), 32'd0);
      if (i >= 1) begin
        chk($sformatf("burst%0d_req", i),  32'(req),  32'd1);
        chk($sformatf("burst%0d_addr", i), 32'(addr), 32'(3 * 320 + 10 + i - 1));
        chk($sformatf("burst%0d_data", i), 32'(data), 32'(16'hA000 + 16'(i - 1)));
      end
    end
    tick();
    chk("burst_end_req",  32'(req),  32'd0);
    chk("burst_end_idle", 32'(idle), 32'd1);

    // Overflow: ack low, 12 pixels into 1 output slot + 8 entries
    ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_pix(1'b1, 16'(i), 16'd10, 2'(i), 16'hC000 + 16'(i));
      tick();
      chk($sformatf("ovf%0d_drop", i), 32'(drop_cnt), (i > 8) ? 32'(i - 8) : 32'd0);
      if (i == 7) chk("ovf7_full", 32'(full), 32'd0);
      if (i >= 8) chk($sformatf("ovf%0d_full", i), 32'(full), 32'd1);
      if (i >= 1) begin
        chk($sformatf("ovf%0d_req", i),  32'(req),  32'd1);
        chk($sformatf("ovf%0d_addr", i), 32'(addr), 32'd3200);
      end
    end

    // Full FIFO, push in the same cycle as an ack-driven pop: nothing dropped
    set_pix(1'b1, 16'd12, 16'd10, 2'd0, 16'hC00C);
    ack = 1'b1;
    tick();
    chk("fpp_req",  32'(req),      32'd1);
    chk("fpp_addr", 32'(addr),     32'd3201);
    chk("fpp_full", 32'(full),     32'd1);
    chk("fpp_drop", 32'(drop_cnt), 32'd3);

    // Drain: p2..p8 then the retained p12
    set_pix(1'b0, 16'd0, 16'd0, 2'd0, 16'd0);
    for (int k = 0; k < 8; k++) begin
      int xi;
      xi = (k < 7) ? k + 2 : 12;
      tick();
      chk($sformatf("drain%0d_req", k),  32'(req),  32'd1);
      chk($sformatf("drain%0d_addr", k), 32'(addr), 32'(3200 + xi));
      chk($sformatf("drain%0d_data", k), 32'(data), 32'(16'hC000 + 16'(xi)));
      if (k == 0) chk("drain0_full", 32'(full), 32'd0);
    end
    tick();
    chk("drain_end_req",  32'(req),      32'd0);
    chk("drain_end_idle", 32'(idle),     32'd1);
    chk("drain_end_drop", 32'(drop_cnt), 32'd3);

    // Reset mid-burst while req is high
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_pix(1'b1, 16'(20 + i), 16'd1, 2'd2, 16'h7000 + 16'(i));
      tick();
    end
    chk("mid_req_before", 32'(req), 32'd1);
    set_pix(1'b0, 16'd0, 16'd0, 2'd0, 16'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req",  32'(req),      32'd0);
    chk("arst_addr", 32'(addr),     32'd0);
    chk("arst_full", 32'(full),     32'd0);
    chk("arst_idle", 32'(idle),     32'd1);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_req",  32'(req),  32'd0);
    chk("post_rst_idle", 32'(idle), 32'd1);
    set_pix(1'b1, 16'd7, 16'd7, 2'd1, 16'h5555);
    tick();
    chk("post_push_idle", 32'(idle), 32'd0);
    set_pix(1'b0, 16'd0, 16'd0, 2'd0, 16'd0);
    tick();
    chk("post_req",  32'(req),  32'd1);
    chk("post_addr", 32'(addr), 32'd2247);
    chk("post_data", 32'(data), 32'h5555);
    ack = 1'b1;
    tick();
    chk("post_end_req",  32'(req),  32'd0);
    chk("post_end_idle", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_framebuffer_writer.md
Name: pixel_framebuffer_writer

Overview:
- Consumes the pixel stream produced by the edge rasterizer: a write strobe plus x, y, depth and color.
- Buffers accepted pixels in a small FIFO and converts (x, y) to a linear framebuffer address.
- Drains the FIFO to the framebuffer SRAM controller over a req/ack write handshake.
- The rasterizer cannot stall, so this block absorbs bursts, drops pixels on overflow with a count, and reports idle so the top-level sequencer knows a triangle is fully committed.

Parameters:
FB_WIDTH, 320, framebuffer width in pixels; x >= FB_WIDTH is clipped
FB_HEIGHT, 240, framebuffer height in pixels; y >= FB_HEIGHT is clipped
ADDR_W, 18, framebuffer address width
FIFO_DEPTH, 8, pixel FIFO entries (power of 2, >= 2)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
in_sig_write_pixel  input  1  pixel valid strobe from rasterizer, one pixel per cycle when high
in_pixel_x  input  16  pixel x coordinate
in_pixel_y  input  16  pixel y coordinate
in_pixel_depth  input  2  pixel depth
in_pixel_color  input  16  pixel color
out_mem_write_req  output  1  write request to SRAM controller
out_mem_addr  output  ADDR_W  write address = y*FB_WIDTH + x
out_mem_data  output  16  color to write
out_mem_depth  output  2  depth accompanying the write
in_mem_write_ack  input  1  controller accepted the current write
out_sig_fifo_full  output  1  FIFO holds FIFO_DEPTH entries
out_sig_writer_idle  output  1  FIFO empty and no write outstanding
out_drop_count  output  16  saturating count of pixels lost to overflow

Behaviour:
- Reset (async, reset_n low): FIFO pointers and occupancy cleared; state IDLE; out_mem_write_req=0; out_mem_addr, out_mem_data, out_mem_depth=0; out_sig_fifo_full=0; out_sig_writer_idle=1; out_drop_count=0. Reset during an outstanding write abandons it immediately; the controller must ignore an ack that arrives after the request has fallen.
- Input stage, each posedge with in_sig_write_pixel=1:
  - If x >= FB_WIDTH or y >= FB_HEIGHT: discard silently. Not counted, not pushed.
  - Else if the FIFO is not full, or a pop occurs in the same cycle: push {addr, color, depth}. addr is computed combinationally as y*FB_WIDTH + x, truncated to ADDR_W.
  - Else: discard and increment out_drop_count, saturating at 16'hFFFF.
- out_sig_fifo_full is registered and reflects occupancy after the edge.
- Write FSM states: IDLE, WRITE.
  - IDLE: if FIFO non-empty at posedge, pop the head into the out_mem_* registers, set out_mem_write_req=1, go to WRITE. A pixel pushed at edge N is popped at edge N+1 at the earliest, so req is high during cycle N+1..N+2. Minimum push-to-req latency is 1 cycle after acceptance.
  - WRITE: hold req, addr, data and depth stable until in_mem_write_ack=1 is sampled at a posedge. On that edge:
    - If the FIFO is non-empty, pop the next entry into the out_mem_* registers and stay in WRITE with req held at 1 (back-to-back, one write per cycle possible).
    - Else set req=0 and go to IDLE.
  - in_mem_write_ack is ignored in IDLE.
- Simultaneous push and pop with the FIFO full: both occur, occupancy stays at FIFO_DEPTH, no drop.
- Simultaneous push and pop with the FIFO empty: not possible, since a pop requires a non-empty FIFO at the edge. The pushed pixel is popped on the following edge.
- out_sig_writer_idle = (FIFO empty) AND (state IDLE), registered. It is 0 from the edge of the first accepted push until the edge that deasserts req with the FIFO empty.
- Ordering: writes issue in strict arrival order. No merging and no reordering.
- Depth is carried through untested; depth compare is out of scope for this block.

Test Plan:
- Single pixel (x=5, y=2, color=16'hF800, depth=1), ack returned 2 cycles after req -> exactly one req with addr=645, data=16'hF800, depth=1; req falls the edge after ack; idle returns to 1.
- 6-pixel back-to-back burst, ack held high -> six consecutive writes in input order, addresses correct, out_drop_count=0, FIFO never full.
- Clipping: pixels (320,0), (0,240) and (319,239) -> only (319,239) is written, at addr=76799; out_drop_count stays 0.
- Overflow: ack held low, 12 pixels pushed with FIFO_DEPTH=8 -> one pixel is in the output registers, 8 are buffered, out_sig_fifo_full=1, out_drop_count=3; after ack is released, all 9 retained pixels are written in order.
- Full with a same-cycle push and ack-driven pop -> occupancy stays 8, the new pixel is retained, drop count is unchanged.
- reset_n pulsed low mid-burst while req=1 -> req drops to 0 asynchronously, FIFO empties, counters clear, idle=1; a new pixel after release is written normally.
